// File: rtl/pixel_driver.sv
// pixel_driver: video timing generator and FIFO-to-RGB unpacker for the HDMI path.
// Optional build macro PIXEL_UNDERFLOW_DET_EN adds a sticky underflow flag and magenta fill on empty reads.
module pixel_driver #(
  parameter int DATA_WIDTH = 64,
  parameter int H_ACTIVE   = 1920,
  parameter int H_FP       = 88,
  parameter int H_SYNC     = 44,
  parameter int H_BP       = 148,
  parameter int V_ACTIVE   = 1080,
  parameter int V_FP       = 4,
  parameter int V_SYNC     = 5,
  parameter int V_BP       = 36,
  parameter int IMG_LINES  = 1075
) (
  input  logic                  pixel_clk,
  input  logic                  rst_n,
  input  logic                  first_fill_flag_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  pixel8_req_o,
  output logic [23:0]           rgb_o,
  output logic                  hsync_o,
  output logic                  vsync_o,
  output logic                  de_o,
  output logic                  underflow_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int PIX_W   = DATA_WIDTH / 2;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_IMG    = VW'(IMG_LINES);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state, state_nxt;
  logic   running;
  logic   fill_meta, fill_s;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;

  logic active0, img_line0, req_cond, hs0, vs0;
  logic rd_d1, uf_d1, odd_d1, act_d1, img_d1, hs_d1, vs_d1;
  logic [PIX_W-1:0] hi_word_q;
  logic             uf_word_q;
  logic [PIX_W-1:0] sel_pix;
  logic             sel_uf;
  logic [23:0]      pix_nxt;
  logic             unused_bits;

  // The fill flag comes from the sdram_clk domain.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_meta <= 1'b0;
      fill_s    <= 1'b0;
    end else begin
      fill_meta <= first_fill_flag_i;
      fill_s    <= fill_meta;
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Once running, only reset returns to IDLE; a dropping fill flag is ignored.
  always_comb begin
    state_nxt = state;
    running   = 1'b0;
    case (state)
      IDLE:    if (fill_s) state_nxt = RUN;
      RUN:     running = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!running) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Stage 0 decode; one FIFO word is fetched at each even active pixel of a stored line.
  always_comb begin
    active0   = running && (h_cnt < H_ACT) && (v_cnt < V_ACT);
    img_line0 = v_cnt < V_IMG;
    req_cond  = active0 && !h_cnt[0] && img_line0;
    hs0       = running && (h_cnt >= HS_START) && (h_cnt < HS_END);
    vs0       = running && (v_cnt >= VS_START) && (v_cnt < VS_END);
  end

  assign pixel8_req_o = req_cond && !fifo_empty_i;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_d1  <= 1'b0;
      uf_d1  <= 1'b0;
      odd_d1 <= 1'b0;
      act_d1 <= 1'b0;
      img_d1 <= 1'b0;
      hs_d1  <= 1'b0;
      vs_d1  <= 1'b0;
    end else begin
      rd_d1  <= pixel8_req_o;
      uf_d1  <= req_cond && fifo_empty_i;
      odd_d1 <= h_cnt[0];
      act_d1 <= active0;
      img_d1 <= img_line0;
      hs_d1  <= hs0;
      vs_d1  <= vs0;
    end
  end

  // Only the upper pixel needs holding; the lower one is used straight off the FIFO bus.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_word_q <= '0;
      uf_word_q <= 1'b0;
    end else if (rd_d1) begin
      hi_word_q <= fifo_data_i[DATA_WIDTH-1:PIX_W];
      uf_word_q <= 1'b0;
    end else if (uf_d1) begin
      hi_word_q <= '0;
      uf_word_q <= 1'b1;
    end
  end

  always_comb begin
    sel_pix = '0;
    sel_uf  = 1'b0;
    if (!odd_d1) begin
      if (rd_d1) sel_pix = fifo_data_i[PIX_W-1:0];
      sel_uf = uf_d1;
    end else begin
      sel_pix = hi_word_q;
      sel_uf  = uf_word_q;
    end
  end

  // Blanking and the unstored tail lines are forced black.
  always_comb begin
    pix_nxt = 24'h000000;
    if (act_d1 && img_d1) begin
`ifdef PIXEL_UNDERFLOW_DET_EN
      pix_nxt = sel_uf ? 24'hFF00FF : sel_pix[23:0];
`else
      pix_nxt = sel_pix[23:0];
`endif
    end
  end

  assign unused_bits = ^{sel_pix[PIX_W-1:24], sel_uf};

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_o   <= 24'h000000;
      de_o    <= 1'b0;
      hsync_o <= 1'b0;
      vsync_o <= 1'b0;
    end else begin
      rgb_o   <= pix_nxt;
      de_o    <= act_d1;
      hsync_o <= hs_d1;
      vsync_o <= vs_d1;
    end
  end

`ifdef PIXEL_UNDERFLOW_DET_EN
  logic underflow_q;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n)     underflow_q <= 1'b0;
    else if (uf_d1) underflow_q <= 1'b1;
  end

  assign underflow_o = underflow_q;
`else
  assign underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_driver.sv
// tb_pixel_driver: directed bench with a FIFO model and a pixel scoreboard, on a shrunken raster.
module tb_pixel_driver;

  localparam int DATA_WIDTH = 64;
  localparam int H_ACTIVE   = 16;
  localparam int H_FP       = 4;
  localparam int H_SYNC     = 3;
  localparam int H_BP       = 5;
  localparam int V_ACTIVE   = 10;
  localparam int V_FP       = 2;
  localparam int V_SYNC     = 2;
  localparam int V_BP       = 3;
  localparam int IMG_LINES  = 8;
  localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int READS_PER_FRAME = IMG_LINES * H_ACTIVE / 2;
  localparam int UF_LINE  = 3;
  localparam int UF_X     = 6;
  localparam int UF_FRAME = 2;
`ifdef PIXEL_UNDERFLOW_DET_EN
  localparam logic [23:0] UF_PIX  = 24'hFF00FF;
  localparam logic        UF_FLAG = 1'b1;
`else
  localparam logic [23:0] UF_PIX  = 24'h000000;
  localparam logic        UF_FLAG = 1'b0;
`endif

  logic                  pixel_clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic                  first_fill_flag_i = 1'b0;
  logic                  fifo_empty_i = 1'b0;
  logic [DATA_WIDTH-1:0] fifo_data_i = '0;
  logic                  pixel8_req_o;
  logic [23:0]           rgb_o;
  logic                  hsync_o, vsync_o, de_o, underflow_o;

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_q[$];
  logic [63:0] preload[$];
  logic [23:0] first_pix[4];
  int  pix_seen;
  int  s_h, s_v, p1_h, p1_v, p2_h, p2_v;
  int  frame_idx, read_cnt, uf_in_frame;
  bit  model_run, idle_mode, look_for_start;
  logic exp_uf;
  bit  uf_armed, uf_done;

  pixel_driver #(
    .DATA_WIDTH(DATA_WIDTH), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .IMG_LINES(IMG_LINES)
  ) dut (
    .pixel_clk(pixel_clk),
    .rst_n(rst_n),
    .first_fill_flag_i(first_fill_flag_i),
    .fifo_empty_i(fifo_empty_i),
    .fifo_data_i(fifo_data_i),
    .pixel8_req_o(pixel8_req_o),
    .rgb_o(rgb_o),
    .hsync_o(hsync_o),
    .vsync_o(vsync_o),
    .de_o(de_o),
    .underflow_o(underflow_o)
  );

  always #5 pixel_clk = ~pixel_clk;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_rgb(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] next_word();
    logic [63:0] w;
    if (preload.size() > 0) w = preload.pop_front();
    else                    w = {$urandom, $urandom};
    return w;
  endfunction

  // Compare all outputs against the raster model for the current cycle.
  task automatic check_cycle();
    logic        exp_de, exp_hs, exp_vs, exp_req;
    logic [23:0] exp_rgb;
    if (!model_run && look_for_start && de_o === 1'b1) begin
      model_run = 1'b1;
      look_for_start = 1'b0;
      p2_h = 0; p2_v = 0;
      p1_h = 1; p1_v = 0;
      s_h  = 2; s_v  = 0;
      frame_idx = 0;
      read_cnt  = 0;
    end
    if (!model_run) begin
      chk_bit("idle_de", de_o, 1'b0);
      chk_bit("idle_hsync", hsync_o, 1'b0);
      chk_bit("idle_vsync", vsync_o, 1'b0);
      chk_rgb("idle_rgb", rgb_o, 24'h000000);
      chk_bit("idle_underflow", underflow_o, 1'b0);
      if (idle_mode || !rst_n) chk_bit("idle_rdreq", pixel8_req_o, 1'b0);
    end else begin
      exp_de  = (p2_h < H_ACTIVE) && (p2_v < V_ACTIVE);
      exp_hs  = (p2_h >= H_ACTIVE + H_FP) && (p2_h < H_ACTIVE + H_FP + H_SYNC);
      exp_vs  = (p2_v >= V_ACTIVE + V_FP) && (p2_v < V_ACTIVE + V_FP + V_SYNC);
      exp_rgb = 24'h000000;
      if (exp_de && p2_v < IMG_LINES) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("[TB] FAIL scoreboard_empty: observed rgb %h expected a queued pixel", rgb_o);
        end
        if (exp_q.size() != 0) exp_rgb = exp_q.pop_front();
        if (pix_seen < 4) begin
          first_pix[pix_seen] = rgb_o;
          pix_seen++;
        end
      end
      chk_bit("de", de_o, exp_de);
      chk_bit("hsync", hsync_o, exp_hs);
      chk_bit("vsync", vsync_o, exp_vs);
      chk_rgb("rgb", rgb_o, exp_rgb);
      chk_bit("underflow", underflow_o, exp_uf);
      exp_req = (s_h < H_ACTIVE) && (s_v < V_ACTIVE) && (s_h % 2 == 0) &&
                (s_v < IMG_LINES) && !fifo_empty_i;
      chk_bit("rdreq", pixel8_req_o, exp_req);
    end
  endtask

  task automatic frame_end();
    if (frame_idx >= 1) chk_int("frame_reads", read_cnt, READS_PER_FRAME - uf_in_frame);
    frame_idx++;
    read_cnt    = 0;
    uf_in_frame = 0;
  endtask

  task automatic advance_model();
    if (model_run) begin
      p2_h = p1_h; p2_v = p1_v;
      p1_h = s_h;  p1_v = s_v;
      if (s_h == H_TOTAL - 1) begin
        s_h = 0;
        if (s_v == V_TOTAL - 1) begin
          s_v = 0;
          frame_end();
        end else begin
          s_v++;
        end
      end else begin
        s_h++;
      end
      if (uf_armed && p2_h == UF_X && p2_v == UF_LINE) begin
        exp_uf   = UF_FLAG;
        uf_armed = 1'b0;
      end
    end
    fifo_empty_i = 1'b0;
    if (model_run && !uf_done && frame_idx == UF_FRAME && s_h == UF_X && s_v == UF_LINE) begin
      fifo_empty_i = 1'b1;
      exp_q.push_back(UF_PIX);
      exp_q.push_back(UF_PIX);
      uf_armed    = 1'b1;
      uf_done     = 1'b1;
      uf_in_frame = 1;
    end
  endtask

  // One pixel clock: check at the falling edge, answer the FIFO read just after the rising edge.
  task automatic applyStimulus();
    logic        req_seen;
    logic [63:0] w;
    @(negedge pixel_clk);
    req_seen = pixel8_req_o;
    check_cycle();
    if (model_run && req_seen === 1'b1) read_cnt++;
    @(posedge pixel_clk);
    #1;
    if (req_seen === 1'b1) begin
      w = next_word();
      fifo_data_i = w;
      exp_q.push_back(w[23:0]);
      exp_q.push_back(w[55:32]);
    end
    advance_model();
  endtask

  task automatic wait_start();
    int n = 0;
    while (!model_run && n < 30) begin
      applyStimulus();
      n++;
    end
    chk_bit("video_start_seen", model_run, 1'b1);
  endtask

  task automatic checkOutput();
    logic [23:0] want [4];
    want[0] = 24'h112233;
    want[1] = 24'hAABBCC;
    want[2] = 24'h445566;
    want[3] = 24'hDDEEFF;
    for (int i = 0; i < 4; i++) chk_rgb($sformatf("unpack_x%0d", i), first_pix[i], want[i]);
  endtask

  initial begin
    int n;
    pix_seen = 0; model_run = 0; look_for_start = 0; idle_mode = 1;
    exp_uf = 1'b0; uf_armed = 0; uf_done = 0; uf_in_frame = 0;
    frame_idx = 0; read_cnt = 0;
    s_h = 0; s_v = 0; p1_h = 0; p1_v = 0; p2_h = 0; p2_v = 0;
    preload.push_back(64'h00AABBCC_00112233);
    preload.push_back(64'h00DDEEFF_00445566);
    $display("[TB] reset and idle phase");
    #2 rst_n = 1'b0;
    repeat (10) applyStimulus();
    rst_n = 1'b1;
    repeat (600) applyStimulus();

    $display("[TB] fill flag raised");
    idle_mode = 0;
    look_for_start = 1;
    first_fill_flag_i = 1'b1;
    wait_start();

    if (model_run) begin
      n = 0;
      while (frame_idx < 3 && n < 5000) begin
        applyStimulus();
        n++;
      end
      chk_int("three_frames_done", frame_idx, 3);
      checkOutput();

      $display("[TB] reset mid-frame");
      n = 0;
      while (!(p2_v == 5 && p2_h == 3) && n < 2000) begin
        applyStimulus();
        n++;
      end
      chk_bit("reached_reset_point", de_o, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk_bit("async_de", de_o, 1'b0);
      chk_bit("async_hsync", hsync_o, 1'b0);
      chk_bit("async_vsync", vsync_o, 1'b0);
      chk_rgb("async_rgb", rgb_o, 24'h000000);
      chk_bit("async_rdreq", pixel8_req_o, 1'b0);
      chk_bit("async_underflow", underflow_o, 1'b0);
      exp_q.delete();
      model_run = 0;
      exp_uf = 1'b0;
      uf_armed = 0;
      uf_in_frame = 0;
      repeat (5) applyStimulus();
      rst_n = 1'b1;
      look_for_start = 1;
      wait_start();
      n = 0;
      while (model_run && frame_idx < 2 && n < 3000) begin
        applyStimulus();
        n++;
      end
      chk_int("restart_frames_done", frame_idx, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
